// File: rtl/sed_check_ctrl.sv
// Sequencer for the soft-error-detection primitive: single-shot or periodic CRC checks,
// forced-error injection, per-check timeout, sticky result flags and check/error counters.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | primitive disabled, waiting for REQ or AUTO
//   S_ARM   | SEDENABLE high for two cycles before the start pulse
//   S_START | SEDSTART high for STARTW cycles
//   S_RUN   | check in progress, timeout counter running
//   S_EVAL  | one cycle to fold the synced SEDERR into the status
//   S_WAIT  | primitive disabled, PERIOD idle cycles before next auto check
module sed_check_ctrl #(
    parameter int PERIOD  = 1024,
    parameter int TIMEOUT = 16777215,
    parameter int STARTW  = 4,
    parameter int CNTW    = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            auto,
    input  logic            req,
    input  logic            inject,
    input  logic            clr,
    input  logic            sederr,
    input  logic            seddone,
    input  logic            sedinprog,
    output logic            sedenable,
    output logic            sedstart,
    output logic            sedfrcerr,
    output logic            busy,
    output logic            pass,
    output logic            fail,
    output logic            tmo,
    output logic [CNTW-1:0] errcnt,
    output logic [CNTW-1:0] chkcnt
);

    localparam int TW = $clog2(TIMEOUT + PERIOD + STARTW + 2);

    localparam logic [TW-1:0] CNT_ONE   = TW'(1);
    localparam logic [TW-1:0] ARM_LD    = TW'(1);
    localparam logic [TW-1:0] START_LD  = TW'(STARTW - 1);
    localparam logic [TW-1:0] RUN_LD    = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] WAIT_LD   = TW'(PERIOD - 1);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_EVAL  = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;

    logic          rst_meta;
    logic          rst_sync;
    logic          sederr_s1, sederr_s2;
    logic          seddone_s1, seddone_s2;
    logic          inprog_s1, inprog_s2;
    logic          done_ok;
    logic          done_prev;
    logic          done_rise;
    logic [2:0]    state, nxt;
    logic [TW-1:0] cnt, cnt_nxt;
    logic          cnt_tc;
    logic          tmo_evt;
    logic          eval_evt;
    logic          inj_pend, inj_nxt;
    logic          en_nxt;
    logic          frc_window;

    // Reset asserts immediately, releases two clk edges after rstn rises.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            sederr_s1  <= 1'b0;
            sederr_s2  <= 1'b0;
            seddone_s1 <= 1'b0;
            seddone_s2 <= 1'b0;
            inprog_s1  <= 1'b0;
            inprog_s2  <= 1'b0;
            done_prev  <= 1'b0;
        end else begin
            sederr_s1  <= sederr;
            sederr_s2  <= sederr_s1;
            seddone_s1 <= seddone;
            seddone_s2 <= seddone_s1;
            inprog_s1  <= sedinprog;
            inprog_s2  <= inprog_s1;
            done_prev  <= done_ok;
        end
    end

    // The primitive drops INPROG as DONE rises; if the two land in different sync
    // cycles the completion edge is deferred by one cycle instead of being lost.
    assign done_ok   = seddone_s2 & ~inprog_s2;
    assign done_rise = done_ok & ~done_prev;
    assign cnt_tc    = (cnt == '0);

    always_comb begin
        nxt      = state;
        cnt_nxt  = cnt;
        tmo_evt  = 1'b0;
        eval_evt = 1'b0;
        case (state)
            S_IDLE: begin
                if (req || auto) begin
                    nxt     = S_ARM;
                    cnt_nxt = ARM_LD;
                end
            end
            S_ARM: begin
                if (cnt_tc) begin
                    nxt     = S_START;
                    cnt_nxt = START_LD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            S_START: begin
                if (cnt_tc) begin
                    nxt     = S_RUN;
                    cnt_nxt = RUN_LD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            S_RUN: begin
                if (done_rise) begin
                    nxt = S_EVAL;
                end else if (cnt_tc) begin
                    tmo_evt = 1'b1;
                    nxt     = auto ? S_WAIT : S_IDLE;
                    cnt_nxt = WAIT_LD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            S_EVAL: begin
                eval_evt = 1'b1;
                nxt      = auto ? S_WAIT : S_IDLE;
                cnt_nxt  = WAIT_LD;
            end
            S_WAIT: begin
                if (!auto) begin
                    nxt = S_IDLE;
                end else if (cnt_tc) begin
                    nxt     = S_ARM;
                    cnt_nxt = ARM_LD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                nxt     = S_IDLE;
                cnt_nxt = '0;
            end
        endcase
    end

    // A fresh INJECT on the cycle the current check ends arms the following check.
    assign inj_nxt    = (inj_pend & ~(eval_evt | tmo_evt)) | inject;
    assign en_nxt     = (nxt != S_IDLE) && (nxt != S_WAIT);
    assign frc_window = (nxt == S_START) || (nxt == S_RUN) || (nxt == S_EVAL);

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            state     <= S_IDLE;
            cnt       <= '0;
            inj_pend  <= 1'b0;
            sedenable <= 1'b0;
            sedstart  <= 1'b0;
            sedfrcerr <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= nxt;
            cnt       <= cnt_nxt;
            inj_pend  <= inj_nxt;
            sedenable <= en_nxt;
            sedstart  <= (nxt == S_START);
            sedfrcerr <= inj_nxt & frc_window;
            busy      <= en_nxt;
        end
    end

    // CLR wins over a same-cycle result; the FSM still advances normally.
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            pass   <= 1'b0;
            fail   <= 1'b0;
            tmo    <= 1'b0;
            errcnt <= '0;
            chkcnt <= '0;
        end else if (clr) begin
            pass   <= 1'b0;
            fail   <= 1'b0;
            tmo    <= 1'b0;
            errcnt <= '0;
            chkcnt <= '0;
        end else begin
            if (tmo_evt) begin
                tmo    <= 1'b1;
                chkcnt <= chkcnt + CNTW'(1);
            end
            if (eval_evt) begin
                chkcnt <= chkcnt + CNTW'(1);
                if (sederr_s2) begin
                    fail <= 1'b1;
                    if (errcnt != CNT_MAX) begin
                        errcnt <= errcnt + CNTW'(1);
                    end
                end else begin
                    pass <= 1'b1;
                end
            end
        end
    end

endmodule
